// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared state, op-class and dec_op range definitions for the core sequencer and decoder
package core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_JAL,
    CL_LUI,
    CL_ILLEGAL
  } op_class_t;

  localparam logic [5:0] OP_ALU_HI   = 6'h12;
  localparam logic [5:0] OP_LOAD_LO  = 6'h13;
  localparam logic [5:0] OP_LOAD_HI  = 6'h17;
  localparam logic [5:0] OP_STORE_LO = 6'h18;
  localparam logic [5:0] OP_STORE_HI = 6'h1A;
  localparam logic [5:0] OP_BR_LO    = 6'h1B;
  localparam logic [5:0] OP_BR_HI    = 6'h1D;
  localparam logic [5:0] OP_BR_ALT   = 6'h20;
  localparam logic [5:0] OP_JAL      = 6'h21;
  localparam logic [5:0] OP_LUI      = 6'h22;
  localparam logic [5:0] OP_ILLEGAL  = 6'h3F;

endpackage

// File: rtl/op_classifier.sv
// rtl/op_classifier.sv - combinational map from decoder class code to instruction class
module op_classifier
  import core_pkg::*;
(
  input  logic [5:0] dec_op,
  output op_class_t  op_class
);

  always_comb begin
    op_class = CL_ILLEGAL;
    if (dec_op <= OP_ALU_HI)
      op_class = CL_ALU;
    else if (dec_op >= OP_LOAD_LO && dec_op <= OP_LOAD_HI)
      op_class = CL_LOAD;
    else if (dec_op >= OP_STORE_LO && dec_op <= OP_STORE_HI)
      op_class = CL_STORE;
    else if ((dec_op >= OP_BR_LO && dec_op <= OP_BR_HI) || dec_op == OP_BR_ALT)
      op_class = CL_BRANCH;
    else if (dec_op == OP_JAL)
      op_class = CL_JAL;
    else if (dec_op == OP_LUI)
      op_class = CL_LUI;
  end

endmodule

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle fetch/decode/exec/mem/wb sequencer with PC and retire counter
module core_sequencer
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  input  logic [5:0]  dec_op,
  input  logic [31:0] immi,
  input  logic        br_taken,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic [31:0] retired,
  output logic        halt
);

  state_t    state_q, state_d;
  op_class_t cls_q, cls_d, exec_cls;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, retired_q, tgt_q, tgt_d;
  logic [31:0] br_tgt, seq_pc;
  logic        ret_inc;

  op_classifier u_op_classifier (
    .dec_op   (dec_op),
    .op_class (exec_cls)
  );

  assign br_tgt = pc_q + immi;
  assign seq_pc = pc_q + 32'd4;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cls_d   = cls_q;
    tgt_d   = tgt_q;
    ret_inc = 1'b0;
    case (state_q)
      ST_IDLE:   if (run) state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        // Class and jump target are captured so MEM/WB do not depend on the decoder holding its outputs.
        cls_d = exec_cls;
        tgt_d = br_tgt;
        case (exec_cls)
          CL_ALU, CL_LUI:   state_d = ST_WB;
          CL_LOAD, CL_STORE: state_d = ST_MEM;
          CL_BRANCH: begin
            if (br_taken && br_tgt[1:0] != 2'b00) begin
              state_d = ST_TRAP;
            end else begin
              pc_d    = br_taken ? br_tgt : seq_pc;
              ret_inc = 1'b1;
              state_d = ST_FETCH;
            end
          end
          CL_JAL:  state_d = (br_tgt[1:0] != 2'b00) ? ST_TRAP : ST_WB;
          default: state_d = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        if (dmem_ack) begin
          if (cls_q == CL_STORE) begin
            pc_d    = seq_pc;
            ret_inc = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        pc_d    = (cls_q == CL_JAL) ? tgt_q : seq_pc;
        ret_inc = 1'b1;
        state_d = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= 32'h0;
      retired_q <= 32'h0;
      cls_q     <= CL_ALU;
      tgt_q     <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cls_q   <= cls_d;
      tgt_q   <= tgt_d;
      if (ret_inc) retired_q <= retired_q + 32'd1;
    end
  end

  assign imem_req  = (state_q == ST_FETCH);
  assign imem_addr = pc_q;
  assign dmem_req  = (state_q == ST_MEM);
  assign dmem_we   = (state_q == ST_MEM) && (cls_q == CL_STORE);
  assign rf_we     = (state_q == ST_WB);
  assign halt      = (state_q == ST_TRAP);
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - directed self-checking bench for core_sequencer
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, imem_ack, br_taken, dmem_ack;
  logic [31:0] imem_rdata, immi;
  logic [5:0]  dec_op;
  logic        imem_req, dmem_req, dmem_we, rf_we, halt;
  logic [31:0] imem_addr, ir, pc, retired;

  int vectors = 0;
  int miscompares = 0;

  core_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .dec_op     (dec_op),
    .immi       (immi),
    .br_taken   (br_taken),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ack   (dmem_ack),
    .rf_we      (rf_we),
    .pc         (pc),
    .retired    (retired),
    .halt       (halt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts in FETCH at a negedge; returns at the negedge after the EXEC cycle.
  task automatic issue(input logic [5:0] op, input logic [31:0] imm, input logic bt,
                       input logic [31:0] word);
    dec_op     = op;
    immi       = imm;
    br_taken   = bt;
    imem_rdata = word;
    imem_ack   = 1'b1;
    @(negedge clk);
    imem_ack   = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  int mem_cycles;
  logic we_seen;

  initial begin
    reset = 1'b0; run = 1'b0; imem_ack = 1'b0; br_taken = 1'b0; dmem_ack = 1'b0;
    imem_rdata = 32'h0; immi = 32'h0; dec_op = 6'h00;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_retired", retired, 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_outs", {27'h0, imem_req, dmem_req, dmem_we, rf_we, halt}, 32'h0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_hold", {31'h0, imem_req}, 32'h0);

    // addi: FETCH, DECODE, EXEC, WB -> rf_we in cycle 4
    run = 1'b1;
    @(negedge clk);
    chk("fetch_req", {31'h0, imem_req}, 32'h1);
    chk("fetch_addr", imem_addr, 32'h0);
    issue(6'h0A, 32'h0, 1'b0, 32'h00A0_0093);
    chk("addi_ir", ir, 32'h00A0_0093);
    chk("addi_rf_we", {31'h0, rf_we}, 32'h1);
    @(negedge clk);
    chk("addi_rf_we_off", {31'h0, rf_we}, 32'h0);
    chk("addi_pc", pc, 32'h4);
    chk("addi_retired", retired, 32'h1);
    chk("addi_next_addr", imem_addr, 32'h4);

    // load with dmem_ack held off for 3 cycles
    issue(6'h15, 32'h0, 1'b0, 32'h0000_2003);
    mem_cycles = 0; we_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (dmem_req) mem_cycles++;
      if (dmem_we) we_seen = 1'b1;
      if (i == 3) dmem_ack = 1'b1;
      @(negedge clk);
    end
    dmem_ack = 1'b0;
    chk("ld_req_cycles", mem_cycles, 32'd4);
    chk("ld_we", {31'h0, we_seen}, 32'h0);
    chk("ld_rf_we", {31'h0, rf_we}, 32'h1);
    chk("ld_dmem_req_off", {31'h0, dmem_req}, 32'h0);
    @(negedge clk);
    chk("ld_pc", pc, 32'h8);
    chk("ld_retired", retired, 32'h2);

    // jal +0xF8 from 0x8 -> 0x100
    issue(6'h21, 32'h0000_00F8, 1'b0, 32'h0F80_006F);
    chk("jal_rf_we", {31'h0, rf_we}, 32'h1);
    @(negedge clk);
    chk("jal_pc", pc, 32'h100);
    chk("jal_retired", retired, 32'h3);

    // beq taken, immi=-8
    issue(6'h1B, 32'hFFFF_FFF8, 1'b1, 32'hFE00_0CE3);
    chk("beq_t_pc", pc, 32'h0F8);
    chk("beq_t_rf_we", {31'h0, rf_we}, 32'h0);
    chk("beq_t_fetch", {31'h0, imem_req}, 32'h1);
    chk("beq_t_retired", retired, 32'h4);

    // beq not taken
    issue(6'h1B, 32'hFFFF_FFF8, 1'b0, 32'hFE00_0CE3);
    chk("beq_nt_pc", pc, 32'h0FC);
    chk("beq_nt_retired", retired, 32'h5);

    // store, zero-wait ack
    issue(6'h19, 32'h0, 1'b0, 32'h0000_2023);
    chk("st_req", {30'h0, dmem_req, dmem_we}, 32'h3);
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("st_pc", pc, 32'h100);
    chk("st_retired", retired, 32'h6);
    chk("st_req_off", {30'h0, dmem_req, rf_we}, 32'h0);

    // branch to the top of the address space, then wrap pc and retired together
    issue(6'h20, 32'hFFFF_FEFC, 1'b1, 32'h0);
    chk("br_top_pc", pc, 32'hFFFF_FFFC);
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    #1;
    chk("preload_retired", retired, 32'hFFFF_FFFF);
    issue(6'h05, 32'h0, 1'b0, 32'h0000_0033);
    chk("wrap_rf_we", {31'h0, rf_we}, 32'h1);
    @(negedge clk);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_retired", retired, 32'h0);

    // lui then misaligned jal
    issue(6'h22, 32'h1234_5000, 1'b0, 32'h1234_50B7);
    chk("lui_rf_we", {31'h0, rf_we}, 32'h1);
    @(negedge clk);
    chk("lui_pc", pc, 32'h4);
    issue(6'h21, 32'h0000_0006, 1'b0, 32'h0060_006F);
    chk("jal_mis_halt", {31'h0, halt}, 32'h1);
    chk("jal_mis_pc", pc, 32'h4);
    chk("jal_mis_retired", retired, 32'h1);
    chk("jal_mis_outs", {28'h0, imem_req, dmem_req, dmem_we, rf_we}, 32'h0);
    imem_ack = 1'b1; dmem_ack = 1'b1;
    repeat (3) @(negedge clk);
    imem_ack = 1'b0; dmem_ack = 1'b0;
    chk("trap_sticky", {27'h0, halt, imem_req, dmem_req, dmem_we, rf_we}, 32'h10);
    chk("trap_pc", pc, 32'h4);

    // reset clears the trap immediately
    run = 1'b0;
    reset = 1'b0;
    #1;
    chk("trap_rst_halt", {31'h0, halt}, 32'h0);
    chk("trap_rst_pc", pc, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    run = 1'b1;
    @(negedge clk);

    // illegal op 0x3F
    issue(6'h3F, 32'h0, 1'b0, 32'hFFFF_FFFF);
    chk("ill_halt", {31'h0, halt}, 32'h1);
    chk("ill_pc", pc, 32'h0);
    chk("ill_retired", retired, 32'h0);

    // reset mid-fetch with the ack still pending
    run = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    run = 1'b1;
    @(negedge clk);
    issue(6'h01, 32'h0, 1'b0, 32'h0000_0013);
    @(negedge clk);
    chk("pre_rst_pc", pc, 32'h4);
    chk("pre_rst_req", {31'h0, imem_req}, 32'h1);
    run = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_req", {31'h0, imem_req}, 32'h0);
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_ir", ir, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    imem_ack = 1'b1;
    repeat (2) @(negedge clk);
    chk("late_ack_req", {31'h0, imem_req}, 32'h0);
    chk("late_ack_ir", ir, 32'h0);
    imem_ack = 1'b0;
    run = 1'b1;
    @(negedge clk);
    chk("refetch_req", {31'h0, imem_req}, 32'h1);
    chk("refetch_addr", imem_addr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
